// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation computing UNROLL rounds per clock.
// ascon_pack holds the state type, round constants and round function.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  localparam logic [7:0] round_constant [16] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3,
    8'hb4, 8'ha5, 8'h96, 8'h87,
    8'h78, 8'h69, 8'h5a, 8'h4b,
    8'h3c, 8'h2d, 8'h1e, 8'h0f
  };

  function automatic logic [63:0] ror(
    input logic [63:0] x,
    input int          n
  );
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state ascon_round(
    input type_state  s,
    input logic [7:0] c
  );
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2];
    x3 = s[3];
    x4 = s[4];
    x2[7:0] = x2[7:0] ^ c;
    // bitsliced 5-bit S-box
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1) ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7) ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

endpackage

module ascon_perm_iter
  import ascon_pack::*;
#(
  parameter int UNROLL     = 1,
  parameter int CONST_BASE = 12
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] rounds_i,
  input  type_state  state_i,
  output logic       ready_o,
  output logic       valid_o,
  output type_state  state_o,
  output logic [3:0] round_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  fsm_t       fsm;
  fsm_t       fsm_nx;
  type_state  work;
  type_state  chain;
  logic [3:0] idx;
  logic [3:0] rem;
  logic [3:0] step;
  logic [3:0] rnds;
  logic       accept;
  logic       last;

  assign rnds = (rounds_i == 4'd0 || rounds_i > 4'd12)
              ? 4'd12 : rounds_i;

  assign step = (rem < 4'(UNROLL)) ? rem : 4'(UNROLL);
  assign last = (rem <= 4'(UNROLL));

  // stages beyond the remaining count pass the state through
  always_comb begin
    chain = work;
    for (int k = 0; k < UNROLL; k++) begin
      if (k < int'(rem)) begin
        chain = ascon_round(chain,
                            round_constant[idx + 4'(k)]);
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_nx;
    end
  end

  always_comb begin
    fsm_nx  = fsm;
    ready_o = 1'b0;
    valid_o = 1'b0;
    accept  = 1'b0;
    unique case (fsm)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          accept = 1'b1;
          fsm_nx = RUN;
        end
      end
      RUN: begin
        if (last) fsm_nx = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        fsm_nx  = IDLE;
      end
      default: fsm_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      work <= '0;
      idx  <= '0;
      rem  <= '0;
    end else if (accept) begin
      work <= state_i;
      idx  <= 4'(CONST_BASE) - rnds;
      rem  <= rnds;
    end else if (fsm == RUN) begin
      work <= chain;
      idx  <= idx + step;
      rem  <= rem - step;
    end
  end

  assign state_o = work;
  assign round_o = (fsm == RUN) ? idx : 4'd0;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Scoreboard bench: UNROLL=1 and UNROLL=4 instances share stimulus and
// are checked against a table-driven column-wise Ascon model.
module tb_ascon_perm_iter;
  import ascon_pack::*;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  typedef struct {
    type_state data;
    int        due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic [3:0] rounds = 4'd0;
  type_state  sin = '0;

  logic       rdy [2];
  logic       vld [2];
  type_state  so  [2];
  logic [3:0] ro  [2];

  exp_t      sb [2][$];
  int        cyc = 0;
  int        free_e [2] = '{0, 0};
  int        acc_e  [2] = '{-1000, -1000};
  int        acc_n  [2] = '{0, 0};
  int        acc_b  [2] = '{0, 0};
  type_state last   [2] = '{default: '0};
  int        checks = 0;
  int        failures = 0;

  int        r_m, n_m, er_m;
  exp_t      e_m, h_m;
  bit        ev_m;
  type_state s_m;

  always #5 clk = ~clk;

  ascon_perm_iter #(.UNROLL(1), .CONST_BASE(12)) dut1 (
    .clock_i (clk),
    .reset_i (rst),
    .start_i (start),
    .rounds_i(rounds),
    .state_i (sin),
    .ready_o (rdy[0]),
    .valid_o (vld[0]),
    .state_o (so[0]),
    .round_o (ro[0])
  );

  ascon_perm_iter #(.UNROLL(4), .CONST_BASE(12)) dut4 (
    .clock_i (clk),
    .reset_i (rst),
    .start_i (start),
    .rounds_i(rounds),
    .state_i (sin),
    .ready_o (rdy[1]),
    .valid_o (vld[1]),
    .state_o (so[1]),
    .round_o (ro[1])
  );

  function automatic int unr(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  function automatic int eff(input int r);
    return (r == 0 || r > 12) ? 12 : r;
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] v,
                                      input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic type_state ref_perm(input type_state s,
                                         input int r);
    logic [63:0] x [5];
    logic [4:0]  col;
    for (int k = 0; k < 5; k++) x[k] = s[k];
    for (int i = 12 - r; i < 12; i++) begin
      x[2][7:0] = x[2][7:0] ^ 8'((15 - i) * 16 + i);
      for (int j = 0; j < 64; j++) begin
        col = SBOX[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
        x[0][j] = col[4];
        x[1][j] = col[3];
        x[2][j] = col[2];
        x[3][j] = col[1];
        x[4][j] = col[0];
      end
      for (int k = 0; k < 5; k++)
        x[k] = x[k] ^ rot(x[k], RA[k]) ^ rot(x[k], RB[k]);
    end
    for (int k = 0; k < 5; k++) s[k] = x[k];
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string nm, input int u,
                     input logic [319:0] act,
                     input logic [319:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s unroll=%0d act=%h req=%h",
               nm, unr(u), act, req);
    end
  endtask

  // reference model: acceptance and expected results per instance
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        sb[u].delete();
        free_e[u] = 0;
        acc_e[u]  = -1000;
        acc_n[u]  = 0;
        last[u]   = '0;
      end
    end else begin
      cyc = cyc + 1;
      for (int u = 0; u < 2; u++) begin
        if (start && cyc >= free_e[u]) begin
          r_m = eff(int'(rounds));
          n_m = (r_m + unr(u) - 1) / unr(u);
          e_m.data = ref_perm(sin, r_m);
          e_m.due  = cyc + n_m;
          sb[u].push_back(e_m);
          free_e[u] = cyc + n_m + 2;
          acc_e[u]  = cyc;
          acc_n[u]  = n_m;
          acc_b[u]  = 12 - r_m;
          last[u]   = e_m.data;
        end
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      chk("ready", u, rdy[u], cyc + 1 >= free_e[u]);
      if (cyc + 1 >= free_e[u]) chk("hold", u, so[u], last[u]);
      if (cyc >= acc_e[u] && cyc < acc_e[u] + acc_n[u])
        er_m = acc_b[u] + (cyc - acc_e[u]) * unr(u);
      else
        er_m = 0;
      chk("round", u, ro[u], er_m);
      ev_m = sb[u].size() > 0 && sb[u][0].due == cyc;
      chk("valid", u, vld[u], ev_m);
      if (ev_m) begin
        h_m = sb[u].pop_front();
        chk("result", u, so[u], h_m.data);
      end
    end
  end

  task automatic pulse(input int r, input type_state s);
    @(negedge clk);
    start  = 1'b1;
    rounds = 4'(r);
    sin    = s;
    @(negedge clk);
    start  = 1'b0;
    rounds = 4'($urandom_range(15));
    sin    = rand_state();
    repeat (16) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pulse(12, '0);
    pulse(6, '0);
    s_m = rand_state();
    pulse(6, s_m);
    pulse(0, s_m);
    pulse(15, s_m);
    pulse(12, s_m);
    for (int r = 1; r <= 12; r++) pulse(r, rand_state());
    // start held high while inputs keep changing
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 120; i++) begin
      rounds = 4'($urandom_range(15));
      sin    = rand_state();
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    // short random starts, many landing while busy
    for (int i = 0; i < 40; i++) begin
      start  = 1'b1;
      rounds = 4'($urandom_range(15));
      sin    = rand_state();
      @(negedge clk);
      start  = 1'b0;
      repeat ($urandom_range(12)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    // reset in the middle of a run
    @(negedge clk);
    start  = 1'b1;
    rounds = 4'd12;
    sin    = rand_state();
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_ready", u, rdy[u], 1);
      chk("rst_valid", u, vld[u], 0);
      chk("rst_state", u, so[u], '0);
      chk("rst_round", u, ro[u], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pulse(12, rand_state());
    pulse(5, rand_state());
    for (int i = 0; i < 40; i++) begin
      if (sb[0].size() == 0 && sb[1].size() == 0) break;
      @(negedge clk);
    end
    for (int u = 0; u < 2; u++)
      chk("drain", u, sb[u].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
